gpio_pin_arb21: RTL and testbench

- Shares one GPIO pin bank (pin_out / n_pin_oe / pin_in) between NUM_REQ on-chip requesters.
- Uses round-robin arbitration with a req/ack handshake and masked per-pin updates.
- Inserts a tristate turnaround window when pin ownership moves to a new requester that enables output drivers.
- Sits between the requesters and the gpio21 pad interface, and returns a synchronized copy of the pad inputs.

---
 rtl/gpio_arb_pkg21.sv | 23 ++
 rtl/gpio_in_sync21.sv | 25 ++
 rtl/gpio_pin_arb21.sv | 148 ++++++++++++++
 tb/tb_gpio_pin_arb21.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg21.sv
// Shared types and constants for the GPIO pin-bank arbiter.
package gpio_arb_pkg21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    APPLY = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_GPIO_W      = 16;
  localparam int DEF_TURN_CYC    = 2;
  localparam int DEF_SYNC_STAGES = 2;

  // Owner field is wide enough for indices 0..7; MSB set means no valid owner.
  localparam int                 OWNER_W   = 4;
  localparam logic [OWNER_W-1:0] LAST_NONE = 4'b1000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_in_sync21.sv
// Multi-stage synchronizer for the pad input bus.
module gpio_in_sync21 #(
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] din,
  output logic [GPIO_W-1:0] dout
);

  logic [GPIO_W-1:0] stg [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign dout = stg[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_pin_arb21.sv
// Round-robin arbiter sharing one GPIO pad bank between several requesters,
// with masked per-pin updates and a tristate turnaround on ownership change.
module gpio_pin_arb21
  import gpio_arb_pkg21::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int GPIO_W      = DEF_GPIO_W,
  parameter int TURN_CYC    = DEF_TURN_CYC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                      pclk21,
  input  logic                      n_p_reset21,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*GPIO_W-1:0] req_mask,
  input  logic [NUM_REQ*GPIO_W-1:0] req_out,
  input  logic [NUM_REQ*GPIO_W-1:0] req_n_oe,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [GPIO_W-1:0]         n_gpio_pin_oe21,
  output logic [GPIO_W-1:0]         gpio_pin_out21,
  input  logic [GPIO_W-1:0]         gpio_pin_in21,
  output logic [GPIO_W-1:0]         pin_in_sync
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = idx_width(TURN_CYC);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  arb_state_e         state, state_nx;
  logic [IW-1:0]      w, w_nx;
  logic [IW-1:0]      rr, rr_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [OWNER_W-1:0] last, last_nx;
  logic [GPIO_W-1:0]  pin_out, out_nx;
  logic [GPIO_W-1:0]  pin_oe, oe_nx;
  logic [NUM_REQ-1:0] ack_r, ack_nx;

  logic               found;
  logic [IW-1:0]      pick;
  logic [GPIO_W-1:0]  pick_mask, pick_noe;
  logic [GPIO_W-1:0]  w_mask, w_out, w_noe;
  logic               turn_need;

  // First set request at or after rr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = rr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign pick_mask = req_mask[int'(pick)*GPIO_W +: GPIO_W];
  assign pick_noe  = req_n_oe[int'(pick)*GPIO_W +: GPIO_W];
  assign w_mask    = req_mask[int'(w)*GPIO_W +: GPIO_W];
  assign w_out     = req_out[int'(w)*GPIO_W +: GPIO_W];
  assign w_noe     = req_n_oe[int'(w)*GPIO_W +: GPIO_W];

  // A zero mask enables nothing, so it never forces a turnaround.
  assign turn_need = (OWNER_W'(pick) != last) && (|(pick_mask & ~pick_noe));

  always_comb begin
    state_nx = state;
    w_nx     = w;
    rr_nx    = rr;
    cnt_nx   = cnt;
    last_nx  = last;
    out_nx   = pin_out;
    oe_nx    = pin_oe;
    ack_nx   = '0;
    case (state)
      IDLE: begin
        if (found) begin
          w_nx = pick;
          if (turn_need) begin
            state_nx = TURN;
            cnt_nx   = TURN_LOAD;
            oe_nx    = pin_oe | pick_mask;
          end else begin
            state_nx = APPLY;
          end
        end
      end
      TURN: begin
        if (cnt == '0) state_nx = APPLY;
        else           cnt_nx   = cnt - CW'(1);
      end
      APPLY: begin
        if (req[w]) begin
          out_nx     = (pin_out & ~w_mask) | (w_out & w_mask);
          oe_nx      = (pin_oe & ~w_mask) | (w_noe & w_mask);
          ack_nx[w]  = 1'b1;
          last_nx    = OWNER_W'(w);
        end else begin
          last_nx    = LAST_NONE;
        end
        rr_nx    = (w == LAST_IDX) ? '0 : w + IW'(1);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk21 or negedge n_p_reset21) begin
    if (!n_p_reset21) begin
      state   <= IDLE;
      w       <= '0;
      rr      <= '0;
      cnt     <= '0;
      last    <= LAST_NONE;
      pin_out <= '0;
      pin_oe  <= '1;
      ack_r   <= '0;
    end else begin
      state   <= state_nx;
      w       <= w_nx;
      rr      <= rr_nx;
      cnt     <= cnt_nx;
      last    <= last_nx;
      pin_out <= out_nx;
      pin_oe  <= oe_nx;
      ack_r   <= ack_nx;
    end
  end

  assign ack             = ack_r;
  assign busy            = (state != IDLE);
  assign gpio_pin_out21  = pin_out;
  assign n_gpio_pin_oe21 = pin_oe;

  gpio_in_sync21 #(
    .GPIO_W      (GPIO_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk   (pclk21),
    .rst_n (n_p_reset21),
    .din   (gpio_pin_in21),
    .dout  (pin_in_sync)
  );

endmodule

// File: tb/tb_gpio_pin_arb21.sv
// Directed bench for gpio_pin_arb21: handshake, round-robin order, turnaround,
// abort, async reset and the input synchronizer.
module tb_gpio_pin_arb21;

  localparam int NR = 4;
  localparam int GW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*GW-1:0] mask = '0;
  logic [NR*GW-1:0] outv = '0;
  logic [NR*GW-1:0] noe = '0;
  logic [GW-1:0]    pin_in = '0;
  logic [NR-1:0]    ack;
  logic             busy;
  logic [GW-1:0]    pin_oe;
  logic [GW-1:0]    pin_out;
  logic [GW-1:0]    pin_sync;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0]  ack_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [15:0] out_seq [5] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'hFFFF};

  always #5 clk = ~clk;

  gpio_pin_arb21 #(
    .NUM_REQ(NR), .GPIO_W(GW), .TURN_CYC(2), .SYNC_STAGES(2)
  ) dut (
    .pclk21          (clk),
    .n_p_reset21     (rst_n),
    .req             (req),
    .req_mask        (mask),
    .req_out         (outv),
    .req_n_oe        (noe),
    .ack             (ack),
    .busy            (busy),
    .n_gpio_pin_oe21 (pin_oe),
    .gpio_pin_out21  (pin_out),
    .gpio_pin_in21   (pin_in),
    .pin_in_sync     (pin_sync)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [15:0] o, input logic [15:0] oe);
    chk({tag, ".out"}, 32'(pin_out), 32'(o));
    chk({tag, ".oe"},  32'(pin_oe),  32'(oe));
  endtask

  task automatic set_req(input int i, input logic [15:0] m, input logic [15:0] o,
                         input logic [15:0] n);
    mask[i*GW +: GW] = m;
    outv[i*GW +: GW] = o;
    noe[i*GW +: GW]  = n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk_pins("rst", 16'h0000, 16'hFFFF);
    chk("rst.ack",  32'(ack),      32'h0);
    chk("rst.busy", 32'(busy),     32'h0);
    chk("rst.sync", 32'(pin_sync), 32'h0);
    rst_n = 1'b1;
    tick();

    // First grant to requester 0 with turnaround
    set_req(0, 16'h00FF, 16'h00A5, 16'h0000);
    req = 4'b0001;
    tick();
    chk("t1.busy", 32'(busy), 32'h1);
    chk_pins("t1.turn0", 16'h0000, 16'hFFFF);
    tick();
    chk("t1.ack1", 32'(ack), 32'h0);
    tick();
    chk("t1.ack2", 32'(ack), 32'h0);
    tick();
    chk("t1.ack3", 32'(ack), 32'h1);
    chk_pins("t1.apply", 16'h00A5, 16'hFF00);
    req = 4'b0000;
    tick();
    chk("t1.ackoff", 32'(ack),  32'h0);
    chk("t1.idle",   32'(busy), 32'h0);

    // Same owner again: no turnaround
    set_req(0, 16'h000F, 16'h0003, 16'h0000);
    req = 4'b0001;
    tick();
    chk("t2.ack0", 32'(ack), 32'h0);
    tick();
    chk("t2.ack1", 32'(ack), 32'h1);
    chk_pins("t2.apply", 16'h00A3, 16'hFF00);
    req = 4'b0000;

    // Mid-cycle reset to get rr_ptr back to 0
    rst_n = 1'b0;
    #1;
    chk_pins("t2.rst", 16'h0000, 16'hFFFF);
    rst_n = 1'b1;

    // All four requesting: round-robin order 0,1,2,3,0
    for (int i = 0; i < NR; i++) set_req(i, 16'h000F << (4 * i), 16'hFFFF, 16'hFFFF);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("rr.gap%0d", g), 32'(ack), 32'h0);
      tick();
      chk($sformatf("rr.ack%0d", g), 32'(ack), 32'(ack_seq[g]));
      chk($sformatf("rr.out%0d", g), 32'(pin_out), 32'(out_seq[g]));
    end
    req = 4'b0000;

    // Requester 1 takes the low-middle nibble, with turnaround
    set_req(1, 16'h00F0, 16'h0050, 16'h0000);
    req = 4'b0010;
    tick();
    tick();
    chk("t3.turn", 32'(ack), 32'h0);
    tick();
    tick();
    chk("t3.ack", 32'(ack), 32'h2);
    chk_pins("t3.apply", 16'hFF5F, 16'hFF0F);
    req = 4'b0000;
    tick();
    chk("t3.idle", 32'(busy), 32'h0);

    // Requester 2 enters turnaround then withdraws
    set_req(2, 16'h00F0, 16'h00A0, 16'h0000);
    set_req(3, 16'hF000, 16'h0000, 16'hFFFF);
    req = 4'b0100;
    tick();
    chk("ab.busy", 32'(busy), 32'h1);
    chk_pins("ab.turn", 16'hFF5F, 16'hFFFF);
    req = 4'b1010;
    tick();
    chk("ab.ack1", 32'(ack), 32'h0);
    tick();
    chk("ab.ack2", 32'(ack), 32'h0);
    tick();
    chk("ab.ack3", 32'(ack),  32'h0);
    chk("ab.idle", 32'(busy), 32'h0);
    chk_pins("ab.pins", 16'hFF5F, 16'hFFFF);
    tick();
    chk("ab.next0", 32'(ack), 32'h0);
    tick();
    chk("ab.next3", 32'(ack), 32'h8);
    chk_pins("ab.next", 16'h0F5F, 16'hFFFF);
    req = 4'b0000;
    tick();
    chk("ab.ackoff", 32'(ack), 32'h0);

    // Input synchronizer latency
    pin_in = 16'h1234;
    tick();
    chk("sync.1", 32'(pin_sync), 32'h0);
    tick();
    chk("sync.2", 32'(pin_sync), 32'h1234);

    // Zero-mask request: acked, pins unchanged, ownership recorded
    set_req(1, 16'h0000, 16'hFFFF, 16'h0000);
    req = 4'b0010;
    tick();
    chk("zm.ack0", 32'(ack), 32'h0);
    tick();
    chk("zm.ack1", 32'(ack), 32'h2);
    chk_pins("zm.pins", 16'h0F5F, 16'hFFFF);
    set_req(1, 16'h000F, 16'h0001, 16'h0000);
    tick();
    chk("zm.own0", 32'(ack), 32'h0);
    tick();
    chk("zm.own1", 32'(ack), 32'h2);
    chk_pins("zm.own", 16'h0F51, 16'hFFF0);
    req = 4'b0000;

    // Asynchronous reset during turnaround
    set_req(2, 16'h0F00, 16'h0000, 16'h0000);
    req = 4'b0100;
    tick();
    chk("ar.busy", 32'(busy), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_pins("ar.pins", 16'h0000, 16'hFFFF);
    chk("ar.busy0", 32'(busy),     32'h0);
    chk("ar.ack",   32'(ack),      32'h0);
    chk("ar.sync",  32'(pin_sync), 32'h0);
    req = 4'b0000;
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar.after", 32'(ack),  32'h0);
    chk("ar.idle",  32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
